// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl
//   Turns the raw PS/2 byte stream into complete key events. It tracks the
//   E0 (extended), F0 (break) and E1 (Pause) prefixes and drops protocol bytes.
//   It recovers from receiver errors and from prefixes that stall. Finished
//   events are queued in a small show-ahead FIFO with a valid/ready output.
//
// Ports
//   clk_i       board clock (single domain)
//   rst_n_i     synchronous reset, active low
//   rx_data_i   received byte, qualified by rx_valid_i
//   rx_valid_i  1-cycle pulse: rx_data_i holds a good byte
//   rx_err_i    1-cycle pulse: receiver packet failed parity/framing
//   ev_valid_o  FIFO non-empty; head event on ev_code_o/ev_ext_o/ev_break_o
//   ev_ready_i  consumer accepts the head event when ev_valid_o & ev_ready_i
//   ev_code_o   scan code with prefixes stripped (8'hE1 = Pause)
//   ev_ext_o    event was E0-prefixed (or Pause)
//   ev_break_o  1 = key release, 0 = key press
//   overflow_o  sticky: an event was dropped because the FIFO was full
//   err_cnt_o   saturating count of receive errors, sequence errors and timeouts
module ps2_key_event_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    input  logic       rx_err_i,
    output logic       ev_valid_o,
    input  logic       ev_ready_i,
    output logic [7:0] ev_code_o,
    output logic       ev_ext_o,
    output logic       ev_break_o,
    output logic       overflow_o,
    output logic [7:0] err_cnt_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK, S_SKIP} state_t;

    state_t        state_q, state_d;
    logic [2:0]    skip_q, skip_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    err_q, err_d;
    logic          ovf_q, ovf_d;
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
    logic [9:0]    head_q, head_d;          // {ext, brk, code}
    logic [9:0]    mem [FIFO_DEPTH];

    logic          push, push_ok, pop, full, empty, err_ev, is_ign;
    logic [9:0]    push_word;

    assign is_ign = rx_data_i inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

    // Prefix sequencer, timeout and error accounting
    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        tmo_d     = tmo_q;
        push      = 1'b0;
        push_word = {2'b00, rx_data_i};
        err_ev    = 1'b0;
        if (rx_err_i) begin
            state_d = S_IDLE;
            skip_d  = 3'd0;
            tmo_d   = '0;
            err_ev  = 1'b1;
        end else if (rx_valid_i) begin
            tmo_d = '0;
            if (state_q == S_SKIP) begin
                // Pause is a fixed 8-byte sequence; swallow the 7 after E1
                if (skip_q == 3'd1) begin
                    push      = 1'b1;
                    push_word = {2'b10, 8'hE1};
                    state_d   = S_IDLE;
                    skip_d    = 3'd0;
                end else begin
                    skip_d = skip_q - 3'd1;
                end
            end else if (rx_data_i == 8'hF0) begin
                if (state_q == S_EXT) begin
                    state_d = S_EXTBRK;
                end else begin
                    state_d = S_BRK;
                    err_ev  = (state_q == S_EXTBRK);
                end
            end else if (rx_data_i == 8'hE0) begin
                state_d = S_EXT;
                err_ev  = (state_q == S_BRK) || (state_q == S_EXTBRK);
            end else if (rx_data_i == 8'hE1) begin
                state_d = S_SKIP;
                skip_d  = 3'd7;
                err_ev  = (state_q != S_IDLE);
            end else if (is_ign) begin
                state_d = S_IDLE;
            end else begin
                push      = 1'b1;
                push_word = {(state_q == S_EXT) || (state_q == S_EXTBRK),
                             (state_q == S_BRK) || (state_q == S_EXTBRK),
                             rx_data_i};
                state_d   = S_IDLE;
            end
        end else if (state_q != S_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                state_d = S_IDLE;
                skip_d  = 3'd0;
                tmo_d   = '0;
                err_ev  = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = '0;
        end

        err_d = err_q;
        if (err_ev && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    // Event FIFO with show-ahead head register
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop     = !empty && ev_ready_i;
    assign push_ok = push && (!full || pop);

    always_comb begin
        wr_d   = wr_q + (AW+1)'(push_ok);
        rd_d   = rd_q + (AW+1)'(pop);
        ovf_d  = ovf_q | (push && full && !pop);
        head_d = head_q;                    // hold last value when going empty
        if (rd_d != wr_d) begin
            // The new head is the entry being written this cycle only when
            // everything older has already been consumed.
            if (rd_d == wr_q) begin
                head_d = push_word;
            end else begin
                head_d = mem[rd_d[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_q[AW-1:0]] <= push_word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            skip_q  <= 3'd0;
            tmo_q   <= '0;
            err_q   <= 8'd0;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            head_q  <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            head_q  <= head_d;
        end
    end

    assign ev_valid_o = !empty;
    assign ev_ext_o   = head_q[9];
    assign ev_break_o = head_q[8];
    assign ev_code_o  = head_q[7:0];
    assign overflow_o = ovf_q;
    assign err_cnt_o  = err_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// tb_ps2_key_event_ctrl
//   Directed bench for ps2_key_event_ctrl. Expected events go into a queue when
//   the completing byte is driven. They are popped and compared as the DUT
//   presents them.
module tb_ps2_key_event_ctrl;
    localparam int DEPTH = 4;
    localparam int TMO   = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_err = 1'b0;
    logic       ev_valid;
    logic       ev_ready = 1'b0;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       overflow;
    logic [7:0] err_cnt;

    int compared   = 0;
    int mismatched = 0;
    logic [9:0] exp_q[$];                   // {ext, brk, code}

    ps2_key_event_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .rx_data_i (rx_data),
        .rx_valid_i(rx_valid),
        .rx_err_i  (rx_err),
        .ev_valid_o(ev_valid),
        .ev_ready_i(ev_ready),
        .ev_code_o (ev_code),
        .ev_ext_o  (ev_ext),
        .ev_break_o(ev_break),
        .overflow_o(overflow),
        .err_cnt_o (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        $display("tx byte %02h", b);
    endtask

    task automatic expect_ev(input logic [7:0] code, input logic ext, input logic brk);
        exp_q.push_back({ext, brk, code});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    // Consume events with ev_ready=1 and compare each against the scoreboard;
    // anything beyond the expected events is an error.
    task automatic drain(input string tag);
        int cyc  = 0;
        int idle = 0;
        logic [9:0] e;
        @(negedge clk);
        ev_ready = 1'b1;
        while (cyc < 40 && (exp_q.size() != 0 || idle < 6)) begin
            if (ev_valid) begin
                compared++;
                assert (exp_q.size() != 0) else begin
                    mismatched++;
                    $error("FAIL %s_spurious: observed event %0h expected none", tag,
                           {ev_ext, ev_break, ev_code});
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk({tag, "_code"}, ev_code, e[7:0]);
                    chk({tag, "_ext"}, ev_ext, e[9]);
                    chk({tag, "_brk"}, ev_break, e[8]);
                    $display("rx event code=%02h ext=%0b brk=%0b", ev_code, ev_ext, ev_break);
                end
                idle = 0;
            end else begin
                idle++;
            end
            cyc++;
            @(negedge clk);
        end
        ev_ready = 1'b0;
        chk({tag, "_missing"}, exp_q.size(), 0);
    endtask

    initial begin
        logic [9:0] e;

        // Reset state
        do_reset();
        chk("rst_valid", ev_valid, 0);
        chk("rst_code", ev_code, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_err", err_cnt, 0);

        // Plain make code, latency 1
        send_byte(8'h1C); expect_ev(8'h1C, 0, 0);
        chk("lat_valid", ev_valid, 1);
        drain("make");

        // Extended break, plain break, ignored bytes
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75); expect_ev(8'h75, 1, 1);
        send_byte(8'hF0); send_byte(8'h1C); expect_ev(8'h1C, 0, 1);
        send_byte(8'hAA); send_byte(8'hFA);
        drain("brk");

        // Pause sequence yields exactly one event
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0);
        chk("pause_early", ev_valid, 0);
        send_byte(8'h77); expect_ev(8'hE1, 1, 0);
        drain("pause");
        chk("pause_err", err_cnt, 0);

        // Receiver error discards a pending E0
        send_byte(8'hE0);
        @(negedge clk); rx_err = 1'b1;
        @(negedge clk); rx_err = 1'b0;
        send_byte(8'h1C); expect_ev(8'h1C, 0, 0);
        chk("rxerr_cnt", err_cnt, 1);
        drain("rxerr");

        // Stalled F0 times out; the next key is a press
        send_byte(8'hF0);
        repeat (TMO - 4) @(negedge clk);
        chk("tmo_early", err_cnt, 1);
        repeat (10) @(negedge clk);
        chk("tmo_cnt", err_cnt, 2);
        send_byte(8'h1C); expect_ev(8'h1C, 0, 0);
        drain("tmo");

        // F0 followed by E0 is a sequence error but continues as extended
        send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h74); expect_ev(8'h74, 1, 0);
        chk("seq_err", err_cnt, 3);
        drain("seq");

        // Full FIFO with simultaneous push and pop: nothing dropped
        do_reset();
        send_byte(8'h15); expect_ev(8'h15, 0, 0);
        send_byte(8'h1D); expect_ev(8'h1D, 0, 0);
        send_byte(8'h24); expect_ev(8'h24, 0, 0);
        send_byte(8'h2D); expect_ev(8'h2D, 0, 0);
        chk("full_ovf0", overflow, 0);
        rx_data  = 8'h35;
        rx_valid = 1'b1;
        ev_ready = 1'b1;
        e = exp_q.pop_front();
        chk("pp_head", ev_code, e[7:0]);
        expect_ev(8'h35, 0, 0);
        @(negedge clk);
        rx_valid = 1'b0;
        ev_ready = 1'b0;
        chk("pp_ovf", overflow, 0);
        drain("pushpop");

        // Overflow: five keys into a depth-4 FIFO
        do_reset();
        send_byte(8'h16); expect_ev(8'h16, 0, 0);
        send_byte(8'h1E); expect_ev(8'h1E, 0, 0);
        send_byte(8'h26); expect_ev(8'h26, 0, 0);
        send_byte(8'h25); expect_ev(8'h25, 0, 0);
        send_byte(8'h2E);
        chk("ovf_set", overflow, 1);
        drain("ovf");
        chk("ovf_sticky", overflow, 1);

        // Reset mid-prefix clears everything
        send_byte(8'h2D);
        send_byte(8'hF0); send_byte(8'hE0);
        chk("pre_rst_err", err_cnt, 1);
        chk("pre_rst_valid", ev_valid, 1);
        do_reset();
        chk("mid_rst_valid", ev_valid, 0);
        chk("mid_rst_code", ev_code, 0);
        chk("mid_rst_ext", ev_ext, 0);
        chk("mid_rst_brk", ev_break, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_err", err_cnt, 0);
        send_byte(8'h75); expect_ev(8'h75, 0, 0);
        drain("postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish");
        $fatal(1, "watchdog");
    end
endmodule
